branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences the branch comparator (brcomp) for conditional branches in the RV32I core.
//  - Accepts one branch op per handshake and drives the comparator operands and I_U select.
//  - Decodes less/equal per funct3 and resolves taken/not-taken against the fetch prediction.
//  - On mispredict, issues a redirect and holds a pipeline flush for FLUSH_CYCLES.
// PARAMETERS
//  XLEN          32  data/PC width
//  FLUSH_CYCLES  2   cycles flush_o is held after a mispredict (>=1)
//  STAT_W        16  width of perf counters (only with BR_STATS_EN)
// PORTS
//  clk           in   1     core clock, rising edge
//  rst_n         in   1     asynchronous reset, active low
//  br_valid_i    in   1     branch op presented
//  br_ready_o    out  1     controller can accept (IDLE only)
//  br_funct3_i   in   3     B-type funct3
//  br_pred_i     in   1     fetch-predicted taken
//  br_pc_i       in   XLEN  branch PC
//  br_imm_i      in   XLEN  sign-extended B-immediate
//  rs1_data_i    in   XLEN  operand 1
//  rs2_data_i    in   XLEN  operand 2
//  abort_i       in   1     higher-priority kill (exception/trap)
//  cmp_rs1_o     out  XLEN  to brcomp.rs1_data (registered)
//  cmp_rs2_o     out  XLEN  to brcomp.rs2_data (registered)
//  cmp_iu_o      out  1     to brcomp.I_U, 1 = unsigned (registered)
//  cmp_less_i    in   1     from brcomp.less
//  cmp_equal_i   in   1     from brcomp.equal
//  resolve_vld_o out  1     1-cycle pulse: branch resolved
//  resolve_tkn_o out  1     resolved direction (valid with resolve_vld_o)
//  illegal_o     out  1     1-cycle pulse: funct3 = 010/011
//  redirect_o    out  1     1-cycle pulse: mispredict, fetch from redirect_pc_o
//  redirect_pc_o out  XLEN  corrected PC
//  flush_o       out  1     flush younger stages
// BEHAVIOUR
//  Reset: all outputs 0 except br_ready_o = 1; state IDLE; comparator regs 0.
//  Handshake: accept at edge where br_valid_i & br_ready_o & !abort_i; latch ops/pc/imm/pred.
//  FSM IDLE -> EVAL on accept. EVAL lasts exactly 1 cycle; brcomp is combinational.
//  cmp_iu_o = 1 for funct3 110/111, else 0; set at accept edge.
//  Taken: 000 eq | 001 !eq | 100 less | 101 !less | 110 less | 111 !less; 010/011 -> not taken.
//  At EVAL exit edge (registered, pulses next cycle): resolve_vld_o = 1, resolve_tkn_o = taken,
//    illegal_o = (funct3 = 010/011), mis = (taken != pred).
//  mis = 1: redirect_o = 1; redirect_pc_o = taken ? pc+imm : pc+4 (mod 2^XLEN, wrap, no flag).
//    EVAL -> FLUSH; flush_o = 1 from redirect cycle for FLUSH_CYCLES cycles (down-counter); -> IDLE.
//  mis = 0: EVAL -> IDLE; redirect_o, flush_o stay 0.
//  Illegal funct3: resolves not taken; mispredict rule still applies.
//  Latency: accept edge N -> resolve_vld_o high in cycle after edge N+1. Throughput: 1 per 2 cycles (no mis).
//  abort_i in IDLE: blocks accept, even with br_valid_i. In EVAL: -> IDLE, no resolve/redirect/flush.
//    In FLUSH: ignored, flush runs to completion.
//  br_ready_o = (state == IDLE); deasserted in EVAL and FLUSH.
//  Async reset mid-op: immediate return to reset values; in-flight branch dropped.
// CONFIGURATION
//  BR_STATS_EN defined: adds outputs stat_br_o, stat_mis_o [STAT_W-1:0].
//    Resolved-branch and mispredict counts; saturate at all-ones; reset 0; abort not counted.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  BEQ rs1=rs2=0x10, pred=1, pc=0x100, imm=0x20 -> resolve_tkn=1, no redirect, ready back 2 cycles after accept.
//  BLT rs1=0xFFFFFFFF, rs2=1, pred=0, pc=0x200, imm=0x40 -> cmp_iu=0, taken, redirect_pc=0x240, flush 2 cycles.
//  BLTU same ops, pred=1, pc=0x300 -> cmp_iu=1, not taken, redirect_pc=0x304.
//  BGE pc=0xFFFFFFF0, imm=0x20, rs1=rs2, pred=0 -> taken, redirect_pc=0x10 (wrap).
//  funct3=010, pred=1 -> illegal_o=1, not taken, redirect to pc+4.
//  abort_i during EVAL -> no resolve/redirect/flush, br_ready_o=1 next cycle; stats unchanged.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: drives the external brcomp comparator and resolves RV32I conditional branches.
// Latency: accept edge N -> resolve/redirect pulse in the cycle after edge N+1; flush_o then held FLUSH_CYCLES.
// Backpressure: br_ready_o high only in IDLE; abort_i blocks accept and cancels a branch still in EVAL.
// Optional feature macro: BR_STATS_EN adds saturating resolved/mispredict counters (stat_br_o, stat_mis_o).
module branch_resolve_ctrl #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int STAT_W       = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            br_valid_i,
   output logic            br_ready_o,
   input  logic [2:0]      br_funct3_i,
   input  logic            br_pred_i,
   input  logic [XLEN-1:0] br_pc_i,
   input  logic [XLEN-1:0] br_imm_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            abort_i,
   output logic [XLEN-1:0] cmp_rs1_o,
   output logic [XLEN-1:0] cmp_rs2_o,
   output logic            cmp_iu_o,
   input  logic            cmp_less_i,
   input  logic            cmp_equal_i,
   output logic            resolve_vld_o,
   output logic            resolve_tkn_o,
   output logic            illegal_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            flush_o
`ifdef BR_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_br_o,
   output logic [STAT_W-1:0] stat_mis_o
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EVAL  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   // The flush counter is loaded with FLUSH_CYCLES-1 on the redirect edge and counts to zero.
   localparam int              CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(4);

   // Refuse to elaborate with a flush window of zero or an empty counter width.
   if (FLUSH_CYCLES < 1 || STAT_W < 1) begin : g_param_check
      $error("branch_resolve_ctrl: FLUSH_CYCLES and STAT_W must both be >= 1");
   end

   // FSM state and the branch captured at accept
   state_t           r_state;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [2:0]       r_funct3;
   logic             r_pred;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_imm;

   // Registered outputs
   logic             r_ready;
   logic [XLEN-1:0]  r_cmp_rs1;
   logic [XLEN-1:0]  r_cmp_rs2;
   logic             r_cmp_iu;
   logic             r_resolve_vld;
   logic             r_resolve_tkn;
   logic             r_illegal;
   logic             r_redirect;
   logic [XLEN-1:0]  r_redirect_pc;
   logic             r_flush;

   // Combinational decode of the comparator result in EVAL
   logic             w_accept;
   logic             w_eval_resolve;
   logic             w_taken;
   logic             w_illegal;
   logic             w_mis;
   logic [XLEN-1:0]  w_target_pc;
   logic [XLEN-1:0]  w_seq_pc;
   logic [XLEN-1:0]  w_redirect_pc;

   // A branch is taken only when the controller is idle and nothing higher-priority is killing the pipe.
   assign w_accept       = br_valid_i & r_ready & ~abort_i;
   // An abort arriving during EVAL drops the branch without any resolve side effects.
   assign w_eval_resolve = (r_state == S_EVAL) & ~abort_i;

   // Map funct3 plus brcomp flags to a direction; reserved encodings resolve not-taken.
   always_comb begin
      w_taken   = 1'b0;
      w_illegal = 1'b0;
      case (r_funct3)
         3'b000:  w_taken = cmp_equal_i;    // BEQ
         3'b001:  w_taken = ~cmp_equal_i;   // BNE
         3'b100:  w_taken = cmp_less_i;     // BLT  (signed compare selected at accept)
         3'b101:  w_taken = ~cmp_less_i;    // BGE
         3'b110:  w_taken = cmp_less_i;     // BLTU (unsigned compare selected at accept)
         3'b111:  w_taken = ~cmp_less_i;    // BGEU
         default: w_illegal = 1'b1;         // 010/011 are not B-type branches
      endcase
   end

   // Both candidate PCs wrap modulo 2^XLEN; the mispredict picks the side fetch did not follow.
   assign w_target_pc   = r_pc + r_imm;
   assign w_seq_pc      = r_pc + PC_STEP;
   assign w_redirect_pc = w_taken ? w_target_pc : w_seq_pc;
   assign w_mis         = w_taken ^ r_pred;

   // Main sequencer: IDLE -> EVAL -> (IDLE | FLUSH -> IDLE) with all outputs registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_flush_cnt   <= '0;
         r_funct3      <= '0;
         r_pred        <= 1'b0;
         r_pc          <= '0;
         r_imm         <= '0;
         r_ready       <= 1'b1;
         r_cmp_rs1     <= '0;
         r_cmp_rs2     <= '0;
         r_cmp_iu      <= 1'b0;
         r_resolve_vld <= 1'b0;
         r_resolve_tkn <= 1'b0;
         r_illegal     <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_flush       <= 1'b0;
      end else begin
         // Pulse outputs default low; only the EVAL exit edge raises them.
         r_resolve_vld <= 1'b0;
         r_resolve_tkn <= 1'b0;
         r_illegal     <= 1'b0;
         r_redirect    <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state   <= S_EVAL;
                  r_ready   <= 1'b0;
                  r_funct3  <= br_funct3_i;
                  r_pred    <= br_pred_i;
                  r_pc      <= br_pc_i;
                  r_imm     <= br_imm_i;
                  r_cmp_rs1 <= rs1_data_i;
                  r_cmp_rs2 <= rs2_data_i;
                  r_cmp_iu  <= (br_funct3_i[2:1] == 2'b11);
               end
            end

            S_EVAL: begin
               if (!w_eval_resolve) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_resolve_vld <= 1'b1;
                  r_resolve_tkn <= w_taken;
                  r_illegal     <= w_illegal;
                  if (w_mis) begin
                     r_redirect    <= 1'b1;
                     r_redirect_pc <= w_redirect_pc;
                     r_flush       <= 1'b1;
                     r_flush_cnt   <= FLUSH_LOAD;
                     r_state       <= S_FLUSH;
                  end else begin
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                  end
               end
            end

            // abort_i is deliberately not looked at here: a started flush always completes.
            S_FLUSH: begin
               if (r_flush_cnt == '0) begin
                  r_flush <= 1'b0;
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_flush_cnt <= r_flush_cnt - CNT_W'(1);
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_flush <= 1'b0;
            end
         endcase
      end
   end

   assign br_ready_o    = r_ready;
   assign cmp_rs1_o     = r_cmp_rs1;
   assign cmp_rs2_o     = r_cmp_rs2;
   assign cmp_iu_o      = r_cmp_iu;
   assign resolve_vld_o = r_resolve_vld;
   assign resolve_tkn_o = r_resolve_tkn;
   assign illegal_o     = r_illegal;
   assign redirect_o    = r_redirect;
   assign redirect_pc_o = r_redirect_pc;
   assign flush_o       = r_flush;

`ifdef BR_STATS_EN
   logic [STAT_W-1:0] r_stat_br;
   logic [STAT_W-1:0] r_stat_mis;

   // Saturating counters bumped on the same edge that raises resolve_vld_o; aborted branches never count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_br  <= '0;
         r_stat_mis <= '0;
      end else if (w_eval_resolve) begin
         if (r_stat_br != '1) begin
            r_stat_br <= r_stat_br + STAT_W'(1);
         end
         if (w_mis && (r_stat_mis != '1)) begin
            r_stat_mis <= r_stat_mis + STAT_W'(1);
         end
      end
   end

   assign stat_br_o  = r_stat_br;
   assign stat_mis_o = r_stat_mis;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed spec cases plus randomized branches.
// A timeline model predicts, per cycle, every output from the branch rules; brcomp is modelled here.
// Literal checks on the directed cases pin the expected values independently of the model.
module tb_branch_resolve_ctrl;

   localparam int FC  = 2;
   localparam int NC  = 4096;
   localparam int BIG = 1 << 30;

   logic        clk;
   logic        rst_n;
   logic        br_valid_i;
   logic        br_ready_o;
   logic [2:0]  br_funct3_i;
   logic        br_pred_i;
   logic [31:0] br_pc_i;
   logic [31:0] br_imm_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic        abort_i;
   logic [31:0] cmp_rs1_o;
   logic [31:0] cmp_rs2_o;
   logic        cmp_iu_o;
   logic        cmp_less_i;
   logic        cmp_equal_i;
   logic        resolve_vld_o;
   logic        resolve_tkn_o;
   logic        illegal_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        flush_o;
`ifdef BR_STATS_EN
   logic [15:0] stat_br_o;
   logic [15:0] stat_mis_o;
`endif

   branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC), .STAT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .br_valid_i(br_valid_i), .br_ready_o(br_ready_o),
      .br_funct3_i(br_funct3_i), .br_pred_i(br_pred_i),
      .br_pc_i(br_pc_i), .br_imm_i(br_imm_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .abort_i(abort_i),
      .cmp_rs1_o(cmp_rs1_o), .cmp_rs2_o(cmp_rs2_o), .cmp_iu_o(cmp_iu_o),
      .cmp_less_i(cmp_less_i), .cmp_equal_i(cmp_equal_i),
      .resolve_vld_o(resolve_vld_o), .resolve_tkn_o(resolve_tkn_o),
      .illegal_o(illegal_o), .redirect_o(redirect_o),
      .redirect_pc_o(redirect_pc_o), .flush_o(flush_o)
`ifdef BR_STATS_EN
      , .stat_br_o(stat_br_o), .stat_mis_o(stat_mis_o)
`endif
   );

   // brcomp: purely combinational comparator fed by the controller's registered operands
   assign cmp_equal_i = (cmp_rs1_o == cmp_rs2_o);
   assign cmp_less_i  = cmp_iu_o ? (cmp_rs1_o < cmp_rs2_o) : ($signed(cmp_rs1_o) < $signed(cmp_rs2_o));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int t     = 0;

   // Expected outputs per cycle index (cycle i = the cycle after the i-th rising edge since reset release)
   bit          e_vld [NC];
   bit          e_tkn [NC];
   bit          e_ill [NC];
   bit          e_red [NC];
   bit          e_fl  [NC];
   logic [31:0] e_pc  [NC];

   int          busy_until;   // first cycle in which br_ready_o is expected high again
   bit          pend;
   int          pend_e;
   logic [2:0]  p_f3;
   bit          p_pred;
   logic [31:0] p_pc, p_imm, p_rs1, p_rs2;
   logic [31:0] cur_rs1, cur_rs2, nxt_rs1, nxt_rs2;
   bit          cur_iu, nxt_iu;
   int          cur_br, cur_mis, nxt_br, nxt_mis;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, t, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NC; i++) begin
         e_vld[i] = 0; e_tkn[i] = 0; e_ill[i] = 0; e_red[i] = 0; e_fl[i] = 0; e_pc[i] = '0;
      end
      busy_until = 0; pend = 0; pend_e = 0;
      cur_rs1 = '0; cur_rs2 = '0; nxt_rs1 = '0; nxt_rs2 = '0; cur_iu = 0; nxt_iu = 0;
      cur_br = 0; cur_mis = 0; nxt_br = 0; nxt_mis = 0;
   endtask

   // Branch rule straight from the ISA: compare operands, pick direction, predict outputs at edge e.
   task automatic resolve_model(input int e);
      bit eq, slt, ult, tk, mis;
      eq  = (p_rs1 == p_rs2);
      slt = ($signed(p_rs1) < $signed(p_rs2));
      ult = (p_rs1 < p_rs2);
      case (p_f3)
         3'd0: tk = eq;
         3'd1: tk = !eq;
         3'd4: tk = slt;
         3'd5: tk = !slt;
         3'd6: tk = ult;
         3'd7: tk = !ult;
         default: tk = 0;
      endcase
      mis      = (tk != p_pred);
      e_vld[e] = 1;
      e_tkn[e] = tk;
      e_ill[e] = (p_f3 == 3'd2) || (p_f3 == 3'd3);
      e_red[e] = mis;
      e_pc[e]  = tk ? (p_pc + p_imm) : (p_pc + 32'd4);
      for (int k = 0; k < FC; k++) e_fl[e + k] = mis;
      busy_until = mis ? e + FC : e;
      if (nxt_br < 65535) nxt_br++;
      if (mis && nxt_mis < 65535) nxt_mis++;
      pend = 0;
   endtask

   task automatic check_cycle();
      chk("ready", br_ready_o, (t >= busy_until));
      chk("resolve_vld", resolve_vld_o, e_vld[t]);
      if (e_vld[t]) chk("resolve_tkn", resolve_tkn_o, e_tkn[t]);
      chk("illegal", illegal_o, e_ill[t]);
      chk("redirect", redirect_o, e_red[t]);
      if (e_red[t]) chk("redirect_pc", redirect_pc_o, e_pc[t]);
      chk("flush", flush_o, e_fl[t]);
      chk("cmp_rs1", cmp_rs1_o, cur_rs1);
      chk("cmp_rs2", cmp_rs2_o, cur_rs2);
      chk("cmp_iu", cmp_iu_o, cur_iu);
`ifdef BR_STATS_EN
      chk("stat_br", stat_br_o, cur_br);
      chk("stat_mis", stat_mis_o, cur_mis);
`endif
   endtask

   // Drive one cycle of inputs (called just after a falling edge), advance the model, then check.
   task automatic step(input bit v, input logic [2:0] f3, input bit pred, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2, input bit ab);
      int e;
      br_valid_i = v; br_funct3_i = f3; br_pred_i = pred; br_pc_i = pc; br_imm_i = imm;
      rs1_data_i = rs1; rs2_data_i = rs2; abort_i = ab;
      e = t + 1;
      if (pend && e == pend_e + 1) begin
         if (ab) begin
            pend = 0;
            busy_until = e;
         end else begin
            resolve_model(e);
         end
      end else if (!pend && t >= busy_until && v && !ab) begin
         pend = 1; pend_e = e;
         p_f3 = f3; p_pred = pred; p_pc = pc; p_imm = imm; p_rs1 = rs1; p_rs2 = rs2;
         nxt_rs1 = rs1; nxt_rs2 = rs2; nxt_iu = (f3 == 3'd6) || (f3 == 3'd7);
         busy_until = BIG;
      end
      @(posedge clk);
      t++;
      @(negedge clk);
      cur_rs1 = nxt_rs1; cur_rs2 = nxt_rs2; cur_iu = nxt_iu;
      cur_br = nxt_br; cur_mis = nxt_mis;
      check_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 3'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int sb, sm;
      logic [12:0] b;
      logic [31:0] r1, r2;
      rst_n = 0; br_valid_i = 0; br_funct3_i = 0; br_pred_i = 0; br_pc_i = 0; br_imm_i = 0;
      rs1_data_i = 0; rs2_data_i = 0; abort_i = 0;
      clear_model();
      repeat (3) @(negedge clk);
      // Reset values
      chk("rst_ready", br_ready_o, 1);
      chk("rst_vld", resolve_vld_o, 0);
      chk("rst_tkn", resolve_tkn_o, 0);
      chk("rst_illegal", illegal_o, 0);
      chk("rst_redirect", redirect_o, 0);
      chk("rst_redirect_pc", redirect_pc_o, 0);
      chk("rst_flush", flush_o, 0);
      chk("rst_cmp_rs1", cmp_rs1_o, 0);
      chk("rst_cmp_iu", cmp_iu_o, 0);
      rst_n = 1;
      t = 0;

      // BEQ equal, predicted taken: no redirect, ready again the cycle after the evaluate edge
      step(1, 3'd0, 1, 32'h100, 32'h20, 32'h10, 32'h10, 0);
      chk("beq_busy", br_ready_o, 0);
      idle(1);
      chk("beq_vld", resolve_vld_o, 1);
      chk("beq_tkn", resolve_tkn_o, 1);
      chk("beq_redirect", redirect_o, 0);
      chk("beq_ready_back", br_ready_o, 1);
      idle(1);

      // BLT -1 < 1 signed, predicted not taken: redirect to target, 2-cycle flush
      step(1, 3'd4, 0, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 0);
      chk("blt_iu", cmp_iu_o, 0);
      idle(1);
      chk("blt_tkn", resolve_tkn_o, 1);
      chk("blt_redirect", redirect_o, 1);
      chk("blt_pc", redirect_pc_o, 32'h240);
      chk("blt_flush1", flush_o, 1);
      idle(1);
      chk("blt_flush2", flush_o, 1);
      chk("blt_busy", br_ready_o, 0);
      idle(1);
      chk("blt_flush_end", flush_o, 0);
      chk("blt_ready", br_ready_o, 1);

      // BLTU same operands, predicted taken: unsigned so not taken, redirect to pc+4
      step(1, 3'd6, 1, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, 0);
      chk("bltu_iu", cmp_iu_o, 1);
      idle(1);
      chk("bltu_tkn", resolve_tkn_o, 0);
      chk("bltu_redirect", redirect_o, 1);
      chk("bltu_pc", redirect_pc_o, 32'h304);
      idle(2);

      // BGE equal operands near the top of the address space: target wraps
      step(1, 3'd5, 0, 32'hFFFF_FFF0, 32'h20, 32'h5, 32'h5, 0);
      idle(1);
      chk("bge_tkn", resolve_tkn_o, 1);
      chk("bge_pc_wrap", redirect_pc_o, 32'h10);
      idle(2);

      // Reserved funct3 resolves not taken and flags illegal
      step(1, 3'd2, 1, 32'h400, 32'h8, 32'h1, 32'h1, 0);
      idle(1);
      chk("ill_flag", illegal_o, 1);
      chk("ill_tkn", resolve_tkn_o, 0);
      chk("ill_pc", redirect_pc_o, 32'h404);
      idle(2);

      // Abort while evaluating: nothing resolves, ready returns at once, stats untouched
      sb = cur_br; sm = cur_mis;
      step(1, 3'd0, 0, 32'h500, 32'h8, 32'h55, 32'h55, 0);
      step(0, 3'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
      chk("abort_vld", resolve_vld_o, 0);
      chk("abort_redirect", redirect_o, 0);
      chk("abort_flush", flush_o, 0);
      chk("abort_ready", br_ready_o, 1);
`ifdef BR_STATS_EN
      chk("abort_stat_br", stat_br_o, sb);
      chk("abort_stat_mis", stat_mis_o, sm);
`endif
      // Abort in IDLE blocks an accept even with valid high
      step(1, 3'd1, 0, 32'h600, 32'h8, 32'h77, 32'h0, 1);
      chk("idle_abort_ready", br_ready_o, 1);
      chk("idle_abort_rs1", cmp_rs1_o, 32'h55);
      idle(1);
      chk("idle_abort_vld", resolve_vld_o, 0);

      // Randomized branches, aborts and back-to-back valids
      for (int i = 0; i < 1500; i++) begin
         b  = 13'($urandom);
         r1 = $urandom;
         case ($urandom_range(0, 3))
            0: r2 = r1;
            1: r2 = r1 ^ 32'h8000_0000;
            default: r2 = $urandom;
         endcase
         step(($urandom_range(0, 9) < 7), 3'($urandom), 1'($urandom), $urandom,
              {{19{b[12]}}, b[12:1], 1'b0}, r1, r2, ($urandom_range(0, 11) == 0));
      end
      idle(4);

      // Asynchronous reset in the middle of a flush
      step(1, 3'd4, 0, 32'h700, 32'h40, 32'hFFFF_FFFF, 32'h1, 0);
      idle(1);
      #2 rst_n = 0;
      #1;
      chk("midrst_ready", br_ready_o, 1);
      chk("midrst_flush", flush_o, 0);
      chk("midrst_redirect", redirect_o, 0);
      chk("midrst_vld", resolve_vld_o, 0);
      chk("midrst_cmp_rs1", cmp_rs1_o, 0);
      chk("midrst_pc", redirect_pc_o, 0);
      @(posedge clk);
      t++;
      @(negedge clk);
      rst_n = 1;
      clear_model();
      check_cycle();
      step(1, 3'd1, 0, 32'h800, 32'h10, 32'h3, 32'h4, 0);
      idle(1);
      chk("post_rst_vld", resolve_vld_o, 1);
      chk("post_rst_tkn", resolve_tkn_o, 1);
      chk("post_rst_pc", redirect_pc_o, 32'h810);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
